seq_divider_16by8: RTL and testbench

//  Sequential restoring divider: QUOT = DIVIDEND / DIVISOR, REM = DIVIDEND % DIVISOR.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 32 +++
 rtl/seq_divider_16by8.sv | 112 +++++++++++
 tb/tb_seq_divider_16by8.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths, FSM state encoding and partial-remainder type for the
// 16-by-8 sequential restoring divider.
package div_pkg;

  localparam int unsigned N_W   = 16;
  localparam int unsigned D_W   = 8;
  localparam int unsigned CNT_W = $clog2(N_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // One guard bit above the divisor width so the trial subtraction never wraps
  typedef logic [D_W:0]       rem_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(N_W - 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and record the quotient bit.
module div_step
  import div_pkg::*;
(
  input  rem_t             i_r,
  input  logic [N_W-1:0]   i_q,
  input  logic [D_W-1:0]   i_d,
  output rem_t             o_r,
  output logic [N_W-1:0]   o_q
);

  logic [D_W+1:0] w_shift;
  rem_t           w_t;
  rem_t           w_d_ext;

  // Trial subtraction; restore (keep the shifted value) when the divisor does not fit
  always_comb begin
    // The partial remainder is always below the divisor, so its top bit is
    // zero and dropping it in the shift loses nothing.
    w_shift = {i_r, i_q[N_W-1]};
    w_t     = w_shift[D_W:0];
    w_d_ext = {1'b0, i_d};
    o_q     = {i_q[N_W-2:0], 1'b0};
    o_r     = w_t;
    if (w_t >= w_d_ext) begin
      o_r    = w_t - w_d_ext;
      o_q[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential 16-by-8 unsigned restoring divider with valid/ready on both
// sides. One quotient bit is produced per clock; divide-by-zero bypasses
// the iteration and reports DIV_BY_ZERO with an all-ones quotient.
module seq_divider_16by8
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   DIVIDEND,
  input  logic [D_W-1:0]   DIVISOR,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_W-1:0]   QUOT,
  output logic [D_W-1:0]   REM,
  output logic             DIV_BY_ZERO
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic             w_accept;

  logic [N_W-1:0]   r_q;
  rem_t             r_r;
  logic [D_W-1:0]   r_d;
  cnt_t             r_cnt;
  logic             r_dbz;

  logic [N_W-1:0]   w_q_nxt;
  rem_t             w_r_nxt;

  div_step u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_nxt),
    .o_q (w_q_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (DIVISOR == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-cycle iteration and result hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (DIVISOR == '0) begin
        r_q   <= '1;
        r_r   <= rem_t'(DIVIDEND[D_W-1:0]);
        r_dbz <= 1'b1;
      end else begin
        r_q   <= DIVIDEND;
        r_r   <= '0;
        r_d   <= DIVISOR;
        r_dbz <= 1'b0;
      end
    end else if (r_state == CALC) begin
      r_q   <= w_q_nxt;
      r_r   <= w_r_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign QUOT        = r_q;
  assign REM         = r_r[D_W-1:0];
  assign DIV_BY_ZERO = r_dbz;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed and randomised checks for the 16-by-8 sequential divider.
module tb_seq_divider_16by8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] DIVIDEND;
  logic [7:0]  DIVISOR;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] QUOT;
  logic [7:0]  REM;
  logic        DIV_BY_ZERO;

  int n_cmp;
  int n_err;

  seq_divider_16by8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .DIVIDEND    (DIVIDEND),
    .DIVISOR     (DIVISOR),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .QUOT        (QUOT),
    .REM         (REM),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation and clock it in; operands are scrambled afterwards
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL start_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1;
    DIVIDEND = a;
    DIVISOR  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    DIVIDEND = 16'hBEEF;
    DIVISOR  = 8'h5A;
  endtask

  // Edges elapsed after the accept edge until out_valid rises (bounded)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_cmp++;
    if (QUOT !== 16'd0) begin n_err++; $display("FAIL reset_quot got=%0d exp=0", QUOT); end
    n_cmp++;
    if (REM !== 8'd0) begin n_err++; $display("FAIL reset_rem got=%0d exp=0", REM); end
    n_cmp++;
    if (DIV_BY_ZERO !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%0b exp=0", DIV_BY_ZERO); end
  endtask

  task automatic test_basic();
    int lat;
    start_op(16'd4816, 8'd112);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 16) begin n_err++; $display("FAIL basic_latency got=%0d exp=16", lat); end
    n_cmp++;
    if (QUOT !== 16'd43) begin n_err++; $display("FAIL basic_quot got=%0d exp=43", QUOT); end
    n_cmp++;
    if (REM !== 8'd0) begin n_err++; $display("FAIL basic_rem got=%0d exp=0", REM); end
    n_cmp++;
    if (DIV_BY_ZERO !== 1'b0) begin n_err++; $display("FAIL basic_dbz got=%0b exp=0", DIV_BY_ZERO); end
    drain();
  endtask

  task automatic test_values();
    logic [15:0] va [5] = '{16'd1000, 16'd65535, 16'd65535, 16'd3,   16'd200};
    logic [7:0]  vb [5] = '{8'd7,     8'd255,    8'd1,      8'd200,  8'd200};
    logic [15:0] vq [5] = '{16'd142,  16'd257,   16'd65535, 16'd0,   16'd1};
    logic [7:0]  vr [5] = '{8'd6,     8'd0,      8'd0,      8'd3,    8'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      wait_valid(lat);
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL values_timeout[%0d] got=%0b exp=1", i, out_valid); end
      n_cmp++;
      if (QUOT !== vq[i]) begin n_err++; $display("FAIL values_quot[%0d] got=%0d exp=%0d", i, QUOT, vq[i]); end
      n_cmp++;
      if (REM !== vr[i]) begin n_err++; $display("FAIL values_rem[%0d] got=%0d exp=%0d", i, REM, vr[i]); end
      n_cmp++;
      if (DIV_BY_ZERO !== 1'b0) begin n_err++; $display("FAIL values_dbz[%0d] got=%0b exp=0", i, DIV_BY_ZERO); end
      drain();
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    start_op(16'd5, 8'd0);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 0) begin n_err++; $display("FAIL dbz_latency got=%0d exp=0", lat); end
    n_cmp++;
    if (QUOT !== 16'hFFFF) begin n_err++; $display("FAIL dbz_quot got=%h exp=ffff", QUOT); end
    n_cmp++;
    if (REM !== 8'd5) begin n_err++; $display("FAIL dbz_rem got=%0d exp=5", REM); end
    n_cmp++;
    if (DIV_BY_ZERO !== 1'b1) begin n_err++; $display("FAIL dbz_flag got=%0b exp=1", DIV_BY_ZERO); end
    drain();
    start_op(16'd300, 8'd0);
    wait_valid(lat);
    n_cmp++;
    if (REM !== 8'd44) begin n_err++; $display("FAIL dbz_rem_trunc got=%0d exp=44", REM); end
    drain();
    start_op(16'd9, 8'd3);
    wait_valid(lat);
    n_cmp++;
    if (DIV_BY_ZERO !== 1'b0 || QUOT !== 16'd3 || REM !== 8'd0) begin
      n_err++;
      $display("FAIL dbz_clear got=%0b/%0d/%0d exp=0/3/0", DIV_BY_ZERO, QUOT, REM);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(16'd1000, 8'd7);
    // A competing request during CALC must not be taken
    in_valid = 1'b1;
    DIVIDEND = 16'd50;
    DIVISOR  = 8'd5;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_calc_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_valid(lat);
    n_cmp++;
    if (QUOT !== 16'd142 || REM !== 8'd6) begin
      n_err++;
      $display("FAIL bp_result got=%0d/%0d exp=142/6", QUOT, REM);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || QUOT !== 16'd142 || REM !== 8'd6 || DIV_BY_ZERO !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got v=%0b r=%0b q=%0d rem=%0d exp v=1 r=0 q=142 rem=6",
                 i, out_valid, in_ready, QUOT, REM);
      end
    end
    drain();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    start_op(16'd4816, 8'd112);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || QUOT !== 16'd0 || REM !== 8'd0) begin
      n_err++;
      $display("FAIL midreset got v=%0b r=%0b q=%0d rem=%0d exp v=0 r=1 q=0 rem=0",
               out_valid, in_ready, QUOT, REM);
    end
    start_op(16'd100, 8'd3);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 16 || QUOT !== 16'd33 || REM !== 8'd1) begin
      n_err++;
      $display("FAIL midreset_next got lat=%0d q=%0d rem=%0d exp lat=16 q=33 rem=1", lat, QUOT, REM);
    end
    drain();
  endtask

  task automatic test_random();
    int unsigned a, b, eq, er, k;
    int lat;
    logic        edbz;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 65535);
      b = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
      if (b == 0) begin
        eq = 32'hFFFF; er = a % 256; edbz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edbz = 1'b0;
      end
      start_op(a[15:0], b[7:0]);
      wait_valid(lat);
      n_cmp++;
      if (lat !== (edbz ? 0 : 16)) begin n_err++; $display("FAIL rnd_latency[%0d] got=%0d", i, lat); end
      k = 0;
      while ($urandom_range(0, 1) == 0 && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      n_cmp++;
      if (out_valid !== 1'b1 || QUOT !== eq[15:0] || REM !== er[7:0] || DIV_BY_ZERO !== edbz) begin
        n_err++;
        $display("FAIL rnd_result[%0d] %0d/%0d got v=%0b q=%0d r=%0d z=%0b exp q=%0d r=%0d z=%0b",
                 i, a, b, out_valid, QUOT, REM, DIV_BY_ZERO, eq, er, edbz);
      end
      if (b != 0) begin
        n_cmp++;
        if ((int'(QUOT) * b + int'(REM)) != a || int'(REM) >= b) begin
          n_err++;
          $display("FAIL rnd_identity[%0d] %0d/%0d got q=%0d r=%0d", i, a, b, QUOT, REM);
        end
      end
      drain();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    DIVIDEND  = '0;
    DIVISOR   = '0;
    test_reset();
    test_basic();
    test_values();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
